spart_tx_sched: RTL and testbench
=================================

# spart_tx_sched

Transmit scheduler for the SPART: generates the baud-rate `tx_enable` tick for the SPART transmitter and shares that transmitter between two byte requesters. Each requester has a one-byte holding register behind a valid/ready handshake. A four-state FSM issues the transmitter's `write` strobe on a tick and then tracks `tbr` through one complete frame before it grants the next byte.

## Interface
- `DIV_W`, 16: width of the baud divisor.
- `DEFAULT_DIV`, 16'd325: divisor loaded at reset.
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `div_in`  in  DIV_W  new divisor value.
- `div_load`  in  1  loads `div_in`; honoured only when `busy`=0.
- `req0_valid` / `req1_valid`  in  1  requester offers a byte.
- `req0_data` / `req1_data`  in  8  offered byte.
- `req0_ready` / `req1_ready`  out  1  holding register empty.
- `tx_enable`  out  1  baud tick to the transmitter; registered, one clk wide.
- `tx_write`  out  1  write strobe to the transmitter.
- `tx_data`  out  8  byte presented to the transmitter.
- `tx_tbr`  in  1  transmitter buffer ready (1 = idle).
- `busy`  out  1  FSM not in IDLE.
- `grant_id`  out  1  port whose byte is in flight or was last sent.

## Operation
- **Baud generator**
  - The down-counter reloads with `max(div,1)-1`.
  - `tx_enable` pulses for one cycle on the cycle after the counter reaches 0, so the tick period is `max(div,1)` clk cycles. `div`=0 or 1 gives a tick every cycle.
  - An accepted `div_load` writes `div` and reloads the counter immediately.
  - `div_load` while `busy`=1 is ignored.
- **Holding registers**
  - `reqN_ready` = !fullN.
  - When `valid&&ready`, the register captures `reqN_data` and sets fullN.
  - fullN is cleared only on that port's write tick. The port can be refilled on the following cycle.
- **FSM states**
  - IDLE: if `tx_tbr`=1 and any fullN, pick a port by arbitration, latch its byte into `tx_data`, set `grant_id`, go to ISSUE.
  - ISSUE: `tx_write` = ISSUE && `tx_enable` (combinational from registered signals). On that tick, clear fullN of the granted port and go to WAIT_LOW.
  - WAIT_LOW: when `tx_tbr`=0, go to WAIT_HIGH.
  - WAIT_HIGH: when `tx_tbr`=1, go to IDLE.
- **Arbitration**
  - Single request: that port is granted.
  - Both ports full: see Configuration.
- **Simultaneous events**
  - A capture on port N in the same cycle as an IDLE grant decision is not visible until the next cycle.
  - A refill on the clear cycle is blocked, because ready is 0 until the clear takes effect.
- **Reset**
  - `state`=IDLE, full0=full1=0, `reqN_ready`=1, `tx_enable`=0, `tx_write`=0, `tx_data`=8'hFF, `busy`=0, `grant_id`=0, `last_grant`=1, `div`=`DEFAULT_DIV`, counter reloaded.
  - Reset mid-frame discards both holding registers. The transmitter shares `rst` and also returns to idle.

## Timing
- Write latency: a byte accepted into an empty scheduler (IDLE, `tx_tbr`=1) on cycle C is granted at C+1 and written on the first tick at or after C+2.
- The transmitter drives `tbr` low one clk after the write tick. It emits start, D0..D7 and stop on the next 10 ticks, and raises `tbr` on the 10th.
- Minimum back-to-back spacing: write ticks are 11 ticks apart. The FSM needs 2 clk after `tbr` rises (WAIT_HIGH→IDLE→ISSUE), so it always catches the next tick when `div`≥3.
- `tx_write` is never asserted outside ISSUE and never without `tx_enable`.

## Configuration
- `SPART_TX_ARB_RR_EN` defined: round-robin. With both ports full, grant the port ≠ `last_grant`, and update `last_grant` on each grant. The first contested grant after reset goes to port 0.
- `SPART_TX_ARB_RR_EN` undefined: fixed priority. Port 0 always wins; `last_grant` is not implemented.

## Test plan
- Reset then single byte: `div`=4, push 8'hA5 on port 0 → one `tx_write` on a tick with `tx_data`=8'hA5. `req0_ready` is low from the cycle after the push until that tick. `busy` returns to 0 one clk after `tbr` rises.
- Contention, RR build: both ports full with 8'h11 (port 0) and 8'h22 (port 1), refilled continuously → write order 11,22,11,22, write ticks exactly 11 ticks apart. Same stimulus in the fixed-priority build → only 8'h11 is sent while port 0 stays full.
- Divisor change: `div_load` with 8 while busy → ignored, tick period stays 4. `div_load` with 8 while idle → next tick 8 cycles later, then every 8. `div`=0 → tick every cycle.
- Tick-aligned handshake: tie `tx_tbr` to a transmitter model and check it never receives `write` while `tbr`=0. Hold `tx_tbr`=1 stuck → FSM stays in WAIT_LOW and issues no further writes.
- Reset mid-frame: assert `rst` at tick 5 of a frame with port 1 full → all outputs return to reset values next cycle, both ready=1, no pending write afterwards.
- Refill race: port 0 valid held high continuously → the new byte is accepted on the cycle after the write tick and written in the next frame, with no byte lost or duplicated over 4 frames.

Source files
------------

// File: rtl/spart_tx_sched.sv
// SPART transmit scheduler: baud tick generator plus a two-port byte scheduler for the transmitter.
// Define SPART_TX_ARB_RR_EN for round-robin arbitration; otherwise port 0 has fixed priority.
module spart_tx_sched #(
    parameter int unsigned      DIV_W       = 16,
    parameter logic [DIV_W-1:0] DEFAULT_DIV = DIV_W'(325)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DIV_W-1:0] div_in,
    input  logic             div_load,
    input  logic             req0_valid,
    input  logic [7:0]       req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [7:0]       req1_data,
    output logic             req1_ready,
    output logic             tx_enable,
    output logic             tx_write,
    output logic [7:0]       tx_data,
    input  logic             tx_tbr,
    output logic             busy,
    output logic             grant_id
);

    typedef enum logic [1:0] {StIdle, StIssue, StWaitLow, StWaitHigh} state_e;

    // Divisors of 0 and 1 both mean a tick every cycle.
    function automatic logic [DIV_W-1:0] reload_of(input logic [DIV_W-1:0] d);
        return (d == '0) ? '0 : d - DIV_W'(1);
    endfunction

    state_e           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d, cnt_q, cnt_d;
    logic             tx_enable_q, tx_enable_d;
    logic [1:0]       full_q, full_d;
    logic [7:0]       hold0_q, hold0_d, hold1_q, hold1_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             grant_q, grant_d;
    logic             div_accept, grant_event, pick;

    // Baud generator
    always_comb begin
        div_accept  = div_load && !busy;
        div_d       = div_q;
        cnt_d       = cnt_q - DIV_W'(1);
        tx_enable_d = 1'b0;
        if (div_accept) begin
            div_d = div_in;
            cnt_d = reload_of(div_in);
        end else if (cnt_q == '0) begin
            cnt_d       = reload_of(div_q);
            tx_enable_d = 1'b1;
        end
    end

    // Holding registers; a port empties only on its own write tick.
    always_comb begin
        full_d  = full_q;
        hold0_d = hold0_q;
        hold1_d = hold1_q;
        if (req0_valid && !full_q[0]) begin
            full_d[0] = 1'b1;
            hold0_d   = req0_data;
        end
        if (req1_valid && !full_q[1]) begin
            full_d[1] = 1'b1;
            hold1_d   = req1_data;
        end
        if (tx_write) begin
            full_d[grant_q] = 1'b0;
        end
    end

    assign grant_event = (state_q == StIdle) && tx_tbr && (|full_q);

`ifdef SPART_TX_ARB_RR_EN
    logic last_grant_q, last_grant_d;

    always_comb begin
        pick         = (&full_q) ? !last_grant_q : !full_q[0];
        last_grant_d = grant_event ? pick : last_grant_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`else
    always_comb begin
        pick = !full_q[0];
    end
`endif

    always_comb begin
        tx_data_d = tx_data_q;
        grant_d   = grant_q;
        if (grant_event) begin
            tx_data_d = pick ? hold1_q : hold0_q;
            grant_d   = pick;
        end
    end

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:     if (tx_tbr && (|full_q)) state_d = StIssue;
            StIssue:    if (tx_enable_q)         state_d = StWaitLow;
            StWaitLow:  if (!tx_tbr)             state_d = StWaitHigh;
            StWaitHigh: if (tx_tbr)              state_d = StIdle;
            default:                             state_d = StIdle;
        endcase
    end

    // FSM: outputs
    always_comb begin
        tx_write = (state_q == StIssue) && tx_enable_q;
        busy     = (state_q != StIdle);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q       <= DEFAULT_DIV;
            cnt_q       <= reload_of(DEFAULT_DIV);
            tx_enable_q <= 1'b0;
            full_q      <= 2'b00;
            hold0_q     <= 8'h00;
            hold1_q     <= 8'h00;
            tx_data_q   <= 8'hFF;
            grant_q     <= 1'b0;
        end else begin
            div_q       <= div_d;
            cnt_q       <= cnt_d;
            tx_enable_q <= tx_enable_d;
            full_q      <= full_d;
            hold0_q     <= hold0_d;
            hold1_q     <= hold1_d;
            tx_data_q   <= tx_data_d;
            grant_q     <= grant_d;
        end
    end

    assign req0_ready = !full_q[0];
    assign req1_ready = !full_q[1];
    assign tx_enable  = tx_enable_q;
    assign tx_data    = tx_data_q;
    assign grant_id   = grant_q;

endmodule

// File: tb/tb_spart_tx_sched.sv
// Self-checking bench for spart_tx_sched with a behavioural SPART transmitter and a byte scoreboard.
module tb_spart_tx_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] div_in = '0;
    logic        div_load = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic [7:0]  req0_data = '0, req1_data = '0;
    logic        req0_ready, req1_ready, tx_enable, tx_write, tx_tbr, busy, grant_id;
    logic [7:0]  tx_data;

    int unsigned n_checks = 0;
    int unsigned n_fail = 0;
    int unsigned cyc = 0;

    spart_tx_sched #(.DIV_W(16), .DEFAULT_DIV(16'd325)) dut (
        .clk(clk), .rst(rst), .div_in(div_in), .div_load(div_load),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .tx_enable(tx_enable), .tx_write(tx_write), .tx_data(tx_data),
        .tx_tbr(tx_tbr), .busy(busy), .grant_id(grant_id)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Transmitter: tbr drops after the write, rises after the 10th following tick.
    logic tbr_q;
    int   tbr_ticks;
    logic tbr_stuck = 1'b0;
    always @(posedge clk) begin
        if (rst) begin
            tbr_q <= 1'b1; tbr_ticks <= 0;
        end else if (tx_write) begin
            tbr_q <= 1'b0; tbr_ticks <= 10;
        end else if (!tbr_q && tx_enable) begin
            tbr_ticks <= tbr_ticks - 1;
            if (tbr_ticks == 1) tbr_q <= 1'b1;
        end
    end
    assign tx_tbr = tbr_stuck ? 1'b1 : tbr_q;

    logic [7:0]  wr_data[$];
    logic        wr_port[$];
    int unsigned wr_cyc[$];
    logic [7:0]  acc0_data[$], acc1_data[$];
    int unsigned acc0_cyc[$];
    int unsigned hs_viol = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (tx_write) begin
                wr_data.push_back(tx_data); wr_port.push_back(grant_id); wr_cyc.push_back(cyc);
                if (!tx_tbr || !tx_enable || !busy) hs_viol <= hs_viol + 1;
            end
            if (req0_valid && req0_ready) begin
                acc0_data.push_back(req0_data); acc0_cyc.push_back(cyc);
            end
            if (req1_valid && req1_ready) acc1_data.push_back(req1_data);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, failures so far %0d", n_fail);
        $fatal(1);
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic clear_logs();
        wr_data.delete(); wr_port.delete(); wr_cyc.delete();
        acc0_data.delete(); acc1_data.delete(); acc0_cyc.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; div_load = 1'b0; tbr_stuck = 1'b0;
        step(); step();
        rst = 1'b0;
        step();
        clear_logs();
    endtask

    task automatic load_div(input logic [15:0] v, output int unsigned l1);
        int unsigned n = 0;
        while (busy && n < 3000) begin step(); n++; end
        div_in = v; div_load = 1'b1;
        step();
        div_load = 1'b0;
        l1 = cyc;
    endtask

    task automatic next_tick(output int unsigned t);
        int unsigned n = 0;
        step();
        while (!tx_enable && n < 2000) begin step(); n++; end
        t = cyc;
    endtask

    task automatic wait_write(output bit ok);
        int unsigned n = 0;
        while (!tx_write && n < 2000) begin step(); n++; end
        ok = tx_write;
    endtask

    task automatic wait_idle(output bit ok);
        int unsigned n = 0;
        while ((busy || !req0_ready || !req1_ready) && n < 5000) begin step(); n++; end
        ok = !busy && req0_ready && req1_ready;
    endtask

    task automatic check_reset_values(input string tag);
        n_checks++; if (req0_ready !== 1'b1) begin n_fail++; $display("FAIL %s_ready0: got %b want 1", tag, req0_ready); end
        n_checks++; if (req1_ready !== 1'b1) begin n_fail++; $display("FAIL %s_ready1: got %b want 1", tag, req1_ready); end
        n_checks++; if (tx_enable !== 1'b0) begin n_fail++; $display("FAIL %s_tx_enable: got %b want 0", tag, tx_enable); end
        n_checks++; if (tx_write !== 1'b0) begin n_fail++; $display("FAIL %s_tx_write: got %b want 0", tag, tx_write); end
        n_checks++; if (tx_data !== 8'hFF) begin n_fail++; $display("FAIL %s_tx_data: got %h want ff", tag, tx_data); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL %s_busy: got %b want 0", tag, busy); end
        n_checks++; if (grant_id !== 1'b0) begin n_fail++; $display("FAIL %s_grant_id: got %b want 0", tag, grant_id); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step();
        check_reset_values("reset");
        rst = 1'b0;
        step();
        clear_logs();
    endtask

    task automatic test_single();
        int unsigned l1, c_push, w;
        bit seen = 1'b0;
        load_div(16'd4, l1);
        req0_valid = 1'b1; req0_data = 8'hA5; c_push = cyc;
        step();
        req0_valid = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            n_checks++;
            if (req0_ready !== 1'b0) begin n_fail++; $display("FAIL single_ready_low: cyc %0d got %b want 0", cyc, req0_ready); end
            if (tx_enable && cyc >= c_push + 2) begin
                seen = 1'b1; w = cyc;
                n_checks++; if (tx_write !== 1'b1) begin n_fail++; $display("FAIL single_write_tick: got %b want 1", tx_write); end
                n_checks++; if (tx_data !== 8'hA5) begin n_fail++; $display("FAIL single_data: got %h want a5", tx_data); end
                n_checks++; if (grant_id !== 1'b0) begin n_fail++; $display("FAIL single_grant: got %b want 0", grant_id); end
            end else begin
                n_checks++; if (tx_write !== 1'b0) begin n_fail++; $display("FAIL single_early_write: cyc %0d got %b want 0", cyc, tx_write); end
                step();
            end
        end
        n_checks++; if (!seen) begin n_fail++; $display("FAIL single_timeout: got no write want one"); end
        step();
        n_checks++; if (req0_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready_back: got %b want 1", req0_ready); end
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            if (tx_tbr) seen = 1'b1; else step();
        end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_at_tbr: got %b want 1", busy); end
        step();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_after_tbr: got %b want 0", busy); end
    endtask

    task automatic test_divisor();
        int unsigned l1, t0, t1;
        bit ok;
        req0_valid = 1'b1; req0_data = 8'($urandom);
        step();
        req0_valid = 1'b0;
        step(); step();
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL div_setup_busy: got %b want 1", busy); end
        div_in = 16'd8; div_load = 1'b1;
        step();
        div_load = 1'b0;
        next_tick(t0);
        for (int i = 0; i < 3; i++) begin
            next_tick(t1);
            n_checks++; if (t1 - t0 != 4) begin n_fail++; $display("FAIL div_ignored_busy: period %0d want 4", t1 - t0); end
            t0 = t1;
        end
        wait_idle(ok);
        load_div(16'd8, l1);
        n_checks++; if (tx_enable !== 1'b0) begin n_fail++; $display("FAIL div8_no_tick_at_load: got %b want 0", tx_enable); end
        next_tick(t0);
        n_checks++; if (t0 != l1 + 8) begin n_fail++; $display("FAIL div8_first_tick: at +%0d want +8", t0 - l1); end
        for (int i = 0; i < 2; i++) begin
            next_tick(t1);
            n_checks++; if (t1 - t0 != 8) begin n_fail++; $display("FAIL div8_period: got %0d want 8", t1 - t0); end
            t0 = t1;
        end
        load_div(16'd0, l1);
        for (int i = 0; i < 8; i++) begin
            step();
            n_checks++; if (tx_enable !== 1'b1) begin n_fail++; $display("FAIL div0_every_cycle: cyc %0d got %b want 1", cyc, tx_enable); end
        end
        load_div(16'd4, l1);
    endtask

    task automatic test_contention();
        int unsigned l1, n = 0;
        logic [7:0] exp;
        do_reset();
        load_div(16'd4, l1);
        req0_valid = 1'b1; req0_data = 8'h11;
        req1_valid = 1'b1; req1_data = 8'h22;
        while (wr_data.size() < 4 && n < 3000) begin step(); n++; end
        req0_valid = 1'b0; req1_valid = 1'b0;
        n_checks++;
        if (wr_data.size() < 4) begin
            n_fail++; $display("FAIL contention_count: got %0d writes want 4", wr_data.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
`ifdef SPART_TX_ARB_RR_EN
                exp = (i % 2 == 1) ? 8'h22 : 8'h11;
`else
                exp = 8'h11;
`endif
                n_checks++; if (wr_data[i] !== exp) begin n_fail++; $display("FAIL contention_order[%0d]: got %h want %h", i, wr_data[i], exp); end
                if (i > 0) begin
                    n_checks++;
                    if (wr_cyc[i] - wr_cyc[i-1] != 44) begin
                        n_fail++; $display("FAIL contention_spacing[%0d]: got %0d cycles want 44", i, wr_cyc[i] - wr_cyc[i-1]);
                    end
                end
            end
        end
    endtask

    task automatic test_stuck_tbr();
        int unsigned l1;
        bit ok;
        do_reset();
        load_div(16'd4, l1);
        tbr_stuck = 1'b1;
        req0_valid = 1'b1; req0_data = 8'hAA; req1_valid = 1'b1; req1_data = 8'hBB;
        step();
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_write(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL stuck_first_write: got none want one"); end
        repeat (200) step();
        n_checks++; if (wr_data.size() != 1) begin n_fail++; $display("FAIL stuck_no_more_writes: got %0d writes want 1", wr_data.size()); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL stuck_busy: got %b want 1", busy); end
        n_checks++; if (req1_ready !== 1'b0) begin n_fail++; $display("FAIL stuck_port1_held: got %b want 0", req1_ready); end
    endtask

    task automatic test_reset_midframe();
        int unsigned l1, t;
        bit ok;
        do_reset();
        load_div(16'd4, l1);
        req0_valid = 1'b1; req0_data = 8'h5A; req1_valid = 1'b1; req1_data = 8'hC3;
        step();
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_write(ok);
        for (int i = 0; i < 5; i++) next_tick(t);
        n_checks++; if (req1_ready !== 1'b0) begin n_fail++; $display("FAIL midframe_port1_full: got %b want 0", req1_ready); end
        rst = 1'b1;
        step();
        check_reset_values("midframe");
        rst = 1'b0;
        clear_logs();
        repeat (150) step();
        n_checks++; if (wr_data.size() != 0) begin n_fail++; $display("FAIL midframe_no_write: got %0d writes want 0", wr_data.size()); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midframe_idle: got busy %b want 0", busy); end
    endtask

    task automatic test_refill();
        int unsigned l1, n = 0;
        bit acc_now;
        do_reset();
        load_div(16'd4, l1);
        req0_valid = 1'b1; req0_data = 8'($urandom);
        while (wr_data.size() < 4 && n < 3000) begin
            acc_now = req0_ready;
            step(); n++;
            if (acc_now) req0_data = 8'($urandom);
        end
        req0_valid = 1'b0;
        n_checks++;
        if (wr_data.size() < 4 || acc0_data.size() < 4) begin
            n_fail++; $display("FAIL refill_count: got %0d writes %0d accepts want 4", wr_data.size(), acc0_data.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++; if (wr_data[i] !== acc0_data[i]) begin n_fail++; $display("FAIL refill_data[%0d]: got %h want %h", i, wr_data[i], acc0_data[i]); end
                if (i < 3) begin
                    n_checks++;
                    if (acc0_cyc[i+1] != wr_cyc[i] + 1) begin
                        n_fail++; $display("FAIL refill_accept_cycle[%0d]: got +%0d want +1", i, acc0_cyc[i+1] - wr_cyc[i]);
                    end
                end
            end
        end
    endtask

    task automatic test_random();
        int unsigned l1, d;
        bit ok;
        logic [7:0] got[$];
        logic [7:0] exp[$];
        do_reset();
        for (int r = 0; r < 3; r++) begin
            d = 3 + $urandom_range(0, 3);
            load_div(16'(d), l1);
            clear_logs();
            for (int i = 0; i < 600; i++) begin
                req0_valid = ($urandom_range(0, 3) == 0); req0_data = 8'($urandom);
                req1_valid = ($urandom_range(0, 3) == 0); req1_data = 8'($urandom);
                step();
            end
            req0_valid = 1'b0; req1_valid = 1'b0;
            wait_idle(ok);
            n_checks++; if (!ok) begin n_fail++; $display("FAIL random_drain[%0d]: busy %b ready %b%b want idle", r, busy, req1_ready, req0_ready); end
            n_checks++; if (wr_data.size() == 0) begin n_fail++; $display("FAIL random_progress[%0d]: got 0 writes want >0", r); end
            for (int p = 0; p < 2; p++) begin
                got.delete();
                foreach (wr_data[i]) if (wr_port[i] == 1'(p)) got.push_back(wr_data[i]);
                exp = (p == 1) ? acc1_data : acc0_data;
                n_checks++;
                if (got.size() != exp.size()) begin
                    n_fail++; $display("FAIL random_count[%0d] port %0d: got %0d want %0d", r, p, got.size(), exp.size());
                end else begin
                    foreach (got[i]) begin
                        n_checks++;
                        if (got[i] !== exp[i]) begin
                            n_fail++; $display("FAIL random_data[%0d] port %0d idx %0d: got %h want %h", r, p, i, got[i], exp[i]);
                        end
                    end
                end
            end
            for (int i = 1; i < wr_cyc.size(); i++) begin
                n_checks++;
                if (wr_cyc[i] - wr_cyc[i-1] < 11 * d) begin
                    n_fail++; $display("FAIL random_spacing[%0d]: got %0d cycles want >= %0d", r, wr_cyc[i] - wr_cyc[i-1], 11 * d);
                end
            end
        end
    endtask

    task automatic test_handshake();
        n_checks++;
        if (hs_viol !== 0) begin n_fail++; $display("FAIL handshake_write_while_tbr_low: got %0d violations want 0", hs_viol); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_divisor();
        test_contention();
        test_refill();
        test_random();
        test_reset_midframe();
        test_stuck_tbr();
        test_handshake();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
